// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: pointer width and Gray/binary conversions.
// Used by both the write-side full generator and the read-side empty generator.
package fifo_pkg;

    // Conversions operate on zero-extended values up to this width.
    localparam int unsigned FUNC_W         = 32;
    localparam int unsigned DEF_ADDR_WIDTH = 4;
    localparam int unsigned DEF_PTR_W      = DEF_ADDR_WIDTH + 1;

    function automatic int unsigned ptr_w(input int unsigned addr_width);
        return addr_width + 1;
    endfunction

    function automatic logic [FUNC_W-1:0] bin2gray(input logic [FUNC_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [FUNC_W-1:0] gray2bin(input logic [FUNC_W-1:0] g);
        logic [FUNC_W-1:0] b;
        b = g;
        for (int unsigned i = 1; i < FUNC_W; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary converter, WIDTH bits (WIDTH <= 32).
module gray_to_bin
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    always_comb begin
        bin = WIDTH'(gray2bin(FUNC_W'(gray)));
    end

endmodule

// File: rtl/wptr_full_gen.sv
// Async FIFO write-side pointer, Gray pointer publication and full/overflow flags.
// Optional WPTR_LEVEL_EN adds registered level and almost_full outputs.
module wptr_full_gen
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned ALMOST_FULL_TH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w_en,
    input  logic [ADDR_WIDTH:0]   rptr_sync,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   wptr,
    output logic                  full,
    output logic                  wr_ack,
    output logic                  overflow
`ifdef WPTR_LEVEL_EN
    ,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  almost_full
`endif
);

    localparam int unsigned PW = ptr_w(ADDR_WIDTH);

    logic [PW-1:0] wbin;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] wgray_next;
    logic [PW-1:0] full_pattern;
    logic          accept;
    logic          full_next;
    logic          overflow_next;

`ifdef WPTR_LEVEL_EN
    logic [PW-1:0] rbin;
    logic [PW-1:0] level_next;
    logic          almost_full_next;

    gray_to_bin #(
        .WIDTH(PW)
    ) u_rptr_to_bin (
        .gray(rptr_sync),
        .bin (rbin)
    );
`endif

    assign waddr = wbin[ADDR_WIDTH-1:0];

    always_comb begin
        accept        = w_en & ~full;
        wbin_next     = wbin + PW'(accept);
        wgray_next    = PW'(bin2gray(FUNC_W'(wbin_next)));
        // Full when the write pointer is one lap ahead: top two Gray bits inverted.
        full_pattern  = {~rptr_sync[ADDR_WIDTH:ADDR_WIDTH-1], rptr_sync[ADDR_WIDTH-2:0]};
        full_next     = (wgray_next == full_pattern);
        overflow_next = overflow | (w_en & full);
`ifdef WPTR_LEVEL_EN
        level_next       = wbin_next - rbin;
        almost_full_next = (32'(level_next) >= ALMOST_FULL_TH);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wbin        <= '0;
            wptr        <= '0;
            full        <= 1'b0;
            wr_ack      <= 1'b0;
            overflow    <= 1'b0;
`ifdef WPTR_LEVEL_EN
            level       <= '0;
            almost_full <= 1'b0;
`endif
        end else begin
            wbin        <= wbin_next;
            wptr        <= wgray_next;
            full        <= full_next;
            wr_ack      <= accept;
            overflow    <= overflow_next;
`ifdef WPTR_LEVEL_EN
            level       <= level_next;
            almost_full <= almost_full_next;
`endif
        end
    end

endmodule

// File: tb/tb_wptr_full_gen.sv
// Directed self-checking bench for wptr_full_gen (ADDR_WIDTH=4, ALMOST_FULL_TH=12).
// Level/almost_full checks are compiled in when WPTR_LEVEL_EN is defined.
module tb_wptr_full_gen;

    localparam int unsigned AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          w_en;
    logic [AW:0]   rptr_sync;
    logic [AW-1:0] waddr;
    logic [AW:0]   wptr;
    logic          full;
    logic          wr_ack;
    logic          overflow;
`ifdef WPTR_LEVEL_EN
    logic [AW:0]   level;
    logic          almost_full;
`endif

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    wptr_full_gen #(
        .ADDR_WIDTH    (AW),
        .ALMOST_FULL_TH(12)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .w_en       (w_en),
        .rptr_sync  (rptr_sync),
        .waddr      (waddr),
        .wptr       (wptr),
        .full       (full),
        .wr_ack     (wr_ack),
        .overflow   (overflow)
`ifdef WPTR_LEVEL_EN
        ,
        .level      (level),
        .almost_full(almost_full)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW:0] gray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [AW:0] eb;
        logic [AW:0] prev;

        // Reset with a concurrent write request.
        rst       = 1'b1;
        w_en      = 1'b1;
        rptr_sync = '0;
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_wptr",     32'(wptr),     32'd0);
            check("rst_waddr",    32'(waddr),    32'd0);
            check("rst_full",     32'(full),     32'd0);
            check("rst_wr_ack",   32'(wr_ack),   32'd0);
            check("rst_overflow", 32'(overflow), 32'd0);
        end

        // Fill 16 entries with rptr_sync parked at 0.
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check("fill_waddr", 32'(waddr), 32'(i));
            step();
            check("fill_wptr",   32'(wptr),   32'(gray(5'(i + 1))));
            check("fill_wr_ack", 32'(wr_ack), 32'd1);
            check("fill_full",   32'(full),   (i == 15) ? 32'd1 : 32'd0);
        end
        check("full_waddr", 32'(waddr), 32'd0);
        check("full_wptr",  32'(wptr),  32'b11000);

        // Writes while full are dropped and set sticky overflow.
        for (int i = 0; i < 3; i++) begin
            step();
            check("ovf_wptr",     32'(wptr),     32'b11000);
            check("ovf_wr_ack",   32'(wr_ack),   32'd0);
            check("ovf_overflow", 32'(overflow), 32'd1);
            check("ovf_full",     32'(full),     32'd1);
        end

        // One pop seen on the synchronized read pointer frees one slot.
        w_en      = 1'b0;
        rptr_sync = 5'b00001;
        step();
        check("pop_full",     32'(full),     32'd0);
        check("pop_overflow", 32'(overflow), 32'd1);
        w_en = 1'b1;
        step();
        check("refill_wptr",   32'(wptr),   32'b11001);
        check("refill_wr_ack", 32'(wr_ack), 32'd1);
        check("refill_full",   32'(full),   32'd1);
        w_en = 1'b0;
        step();
        check("hold_overflow", 32'(overflow), 32'd1);

        rst = 1'b1;
        step();
        check("rst2_overflow", 32'(overflow), 32'd0);
        check("rst2_wptr",     32'(wptr),     32'd0);
        rst = 1'b0;

        // Wrap: 40 writes with the read pointer trailing by 5.
        eb = '0;
        for (int k = 0; k < 40; k++) begin
            rptr_sync = (k >= 5) ? gray(5'(k - 5)) : '0;
            w_en      = 1'b1;
            prev      = wptr;
            step();
            eb = eb + 5'd1;
            check("wrap_wptr",   32'(wptr),                 32'(gray(eb)));
            check("wrap_1bit",   32'($countones(prev ^ wptr)), 32'd1);
            check("wrap_full",   32'(full),                 32'd0);
        end
        check("wrap_waddr", 32'(waddr), 32'd8);
        w_en = 1'b0;

`ifdef WPTR_LEVEL_EN
        rst = 1'b1;
        step();
        rst       = 1'b0;
        rptr_sync = '0;
        w_en      = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            check("lvl_level", 32'(level),       32'(i + 1));
            check("lvl_af",    32'(almost_full), (i == 11) ? 32'd1 : 32'd0);
        end
        w_en      = 1'b0;
        rptr_sync = gray(5'd3);
        step();
        check("lvl_pop_level", 32'(level),       32'd9);
        check("lvl_pop_af",    32'(almost_full), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
